// File: rtl/vc_credit_counter_pkg.sv
// Shared router definitions for the VC credit tracker: default sizing, width helper,
// credit limit and the counter type.
package vc_credit_counter_pkg;

  localparam int VC_NUM_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = int'(i) + 1;
    end
    return r;
  endfunction

  localparam int CRED_MAX = DEPTH_DEF;
  localparam int CW_DEF   = clog2(CRED_MAX + 1);

  typedef logic [CW_DEF-1:0] cred_cnt_t;

endpackage

// File: rtl/vc_credit_slice.sv
// One VC's credit counter: cnt + credit_in - flit_sent via 3:2 carry-save compression
// and a carry-propagate add, with saturation and sticky error flags.
module vc_credit_slice
  import vc_credit_counter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          credit_in,
  input  logic          flit_sent,
  output logic [CW-1:0] cnt,
  output logic          err_ovf,
  output logic          err_udf
);

  logic [CW-1:0] x, y, c, s, co, sum;
  logic          ovf, udf;

  // flit_sent contributes all-ones, i.e. -1 in two's complement
  always_comb begin
    x   = cnt;
    y   = CW'(credit_in);
    c   = {CW{flit_sent}};
    s   = x ^ y ^ c;
    co  = (x & y) | (x & c) | (y & c);
    sum = s + (co << 1);
  end

  // Saturation is judged on the registered count, so the wrapped sum is never written
  always_comb begin
    ovf = credit_in & ~flit_sent & (cnt == CW'(DEPTH));
    udf = ~credit_in & flit_sent & (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CW'(DEPTH);
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (!(ovf | udf)) cnt <= sum;
      if (ovf) err_ovf <= 1'b1;
      if (udf) err_udf <= 1'b1;
    end
  end

endmodule

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit tracker for the router output port.
// Optional CREDIT_BYPASS_EN: a credit returned this cycle also raises credit_avail.
module vc_credit_counter
  import vc_credit_counter_pkg::*;
#(
  parameter int  VC_NUM = VC_NUM_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int CW     = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VC_NUM-1:0]    credit_in,
  input  logic [VC_NUM-1:0]    flit_sent,
  output logic [VC_NUM-1:0]    credit_avail,
  output logic [VC_NUM*CW-1:0] credit_cnt,
  output logic [VC_NUM-1:0]    err_ovf,
  output logic [VC_NUM-1:0]    err_udf
);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_credit_slice #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .credit_in (credit_in[v]),
      .flit_sent (flit_sent[v]),
      .cnt       (credit_cnt[v*CW +: CW]),
      .err_ovf   (err_ovf[v]),
      .err_udf   (err_udf[v])
    );
  end

  always_comb begin
    credit_avail = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
`ifdef CREDIT_BYPASS_EN
      credit_avail[v] = (|credit_cnt[v*CW +: CW]) | credit_in[v];
`else
      credit_avail[v] = |credit_cnt[v*CW +: CW];
`endif
    end
  end

endmodule
